// File: rtl/pfetch.sv
// ============================================================================
// pfetch -- instruction fetch stage in front of the combinational program ROM
//
// Owns the program counter, presents it to the ROM as padr, and captures the
// returned word into a registered IR that decode/execute consume together
// with its fetch address and a valid flag. Start, redirect and stall control
// are applied here. The block also reports when the processor is parked in
// its idle loop at IDLE_ADR.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active-high
//   proc_start in   1   pulse: leave the idle loop, fetch from START_ADR
//   stall      in   1   hold pc and IR
//   redir_en   in   1   taken branch/jump from execute
//   redir_adr  in   AW  redirect target
//   padr       out  AW  ROM address (the pc register)
//   dout       in   IW  ROM data for padr, same cycle
//   ir         out  IW  registered instruction
//   ir_pc      out  AW  address ir was fetched from
//   ir_valid   out  1   ir holds a live instruction
//   ir_taken   out  1   ir is a JMP already redirected by fetch
//   proc_ready out  1   processor idle in the loop at IDLE_ADR
//
// Build option:
//   FETCH_JMP_PREDECODE_EN -- when defined, unconditional JMPs are detected
//   on the ROM data and followed in fetch with no bubble. When undefined,
//   JMPs are left to execute and ir_taken is constant 0.
// ============================================================================
module pfetch #(
    parameter int          AW        = 13,
    parameter int          IW        = 18,
    parameter logic [AW-1:0] START_ADR = 13'd1,
    parameter logic [AW-1:0] IDLE_ADR  = 13'd0,
    parameter logic [4:0]  JMP_OP    = 5'b11010
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          proc_start,
    input  logic          stall,
    input  logic          redir_en,
    input  logic [AW-1:0] redir_adr,
    output logic [AW-1:0] padr,
    input  logic [IW-1:0] dout,
    output logic [IW-1:0] ir,
    output logic [AW-1:0] ir_pc,
    output logic          ir_valid,
    output logic          ir_taken,
    output logic          proc_ready
);

`ifdef FETCH_JMP_PREDECODE_EN
    localparam bit PREDECODE = 1'b1;
`else
    localparam bit PREDECODE = 1'b0;
`endif

    logic [AW-1:0] pc;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] jmp_tgt;
    logic          is_jmp;
    logic          taken_q;

    // Sequential successor wraps modulo 2^AW; the jump target sits in the
    // low address bits of the JMP word. With predecode disabled is_jmp is
    // tied low so the JMP path folds away entirely.
    always_comb begin
        pc_inc  = pc + AW'(1);
        jmp_tgt = dout[AW-1:0];
        is_jmp  = PREDECODE && (dout[IW-1:IW-5] == JMP_OP);
    end

    // Fetch pipeline register. Priority per edge is start, then redirect,
    // then stall, then a normal fetch. A start or redirect drops ir_valid
    // for one cycle because the word on dout belongs to the abandoned path.
    // proc_ready only moves on start, redirect or a predecoded jump, so a
    // plain pc wrap into IDLE_ADR leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= IDLE_ADR;
            ir         <= '0;
            ir_pc      <= '0;
            ir_valid   <= 1'b0;
            taken_q    <= 1'b0;
            proc_ready <= 1'b1;
        end else if (proc_start) begin
            pc         <= START_ADR;
            ir_valid   <= 1'b0;
            taken_q    <= 1'b0;
            proc_ready <= 1'b0;
        end else if (redir_en) begin
            pc         <= redir_adr;
            ir_valid   <= 1'b0;
            taken_q    <= 1'b0;
            proc_ready <= (redir_adr == IDLE_ADR);
        end else if (!stall) begin
            ir       <= dout;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (is_jmp) begin
                pc         <= jmp_tgt;
                taken_q    <= 1'b1;
                proc_ready <= (jmp_tgt == IDLE_ADR);
            end else begin
                pc      <= pc_inc;
                taken_q <= 1'b0;
            end
        end
    end

    assign padr     = pc;
    assign ir_taken = taken_q;

endmodule

// File: tb/tb_pfetch.sv
// ============================================================================
// tb_pfetch -- directed self-checking bench for the fetch stage
//
// The ROM model returns {5'b00001, addr} for every address, except one
// optional address that can be programmed to return "JMP 0".
// ============================================================================
module tb_pfetch;

    localparam int AW = 13;
    localparam int IW = 18;

    logic          clk;
    logic          rst;
    logic          proc_start;
    logic          stall;
    logic          redir_en;
    logic [AW-1:0] redir_adr;
    logic [AW-1:0] padr;
    logic [IW-1:0] dout;
    logic [IW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_taken;
    logic          proc_ready;

    logic          jmp_en;
    logic [AW-1:0] jmp_at;

    int total = 0;
    int bad   = 0;

    pfetch dut (
        .clk        (clk),
        .rst        (rst),
        .proc_start (proc_start),
        .stall      (stall),
        .redir_en   (redir_en),
        .redir_adr  (redir_adr),
        .padr       (padr),
        .dout       (dout),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_taken   (ir_taken),
        .proc_ready (proc_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational ROM model
    function automatic logic [IW-1:0] word_at(input logic [AW-1:0] a);
        return {5'b00001, a};
    endfunction

    assign dout = (jmp_en && padr == jmp_at) ? {5'b11010, 13'd0} : word_at(padr);

    // Advance one edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (padr !== 13'd0) begin bad++; $display("[TB] FAIL reset_padr got=%0d exp=0", padr); end
        total++; if (ir !== 18'd0) begin bad++; $display("[TB] FAIL reset_ir got=%h exp=0", ir); end
        total++; if (ir_pc !== 13'd0) begin bad++; $display("[TB] FAIL reset_ir_pc got=%0d exp=0", ir_pc); end
        total++; if (ir_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", ir_valid); end
        total++; if (ir_taken !== 1'b0) begin bad++; $display("[TB] FAIL reset_taken got=%b exp=0", ir_taken); end
        total++; if (proc_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=1", proc_ready); end
        step();
        total++; if (padr !== 13'd0) begin bad++; $display("[TB] FAIL reset_hold_padr got=%0d exp=0", padr); end
        rst = 1'b0;
    endtask

    task automatic test_start();
        proc_start = 1'b1;
        step();
        proc_start = 1'b0;
        total++; if (padr !== 13'd1) begin bad++; $display("[TB] FAIL start_padr got=%0d exp=1", padr); end
        total++; if (ir_valid !== 1'b0) begin bad++; $display("[TB] FAIL start_valid got=%b exp=0", ir_valid); end
        total++; if (proc_ready !== 1'b0) begin bad++; $display("[TB] FAIL start_ready got=%b exp=0", proc_ready); end
        for (int i = 1; i <= 5; i++) begin
            step();
            total++; if (ir_pc !== AW'(i)) begin bad++; $display("[TB] FAIL start_ir_pc got=%0d exp=%0d", ir_pc, i); end
            total++; if (ir !== word_at(AW'(i))) begin bad++; $display("[TB] FAIL start_ir got=%h exp=%h", ir, word_at(AW'(i))); end
            total++; if (ir_valid !== 1'b1) begin bad++; $display("[TB] FAIL start_ir_valid got=%b exp=1", ir_valid); end
            total++; if (proc_ready !== 1'b0) begin bad++; $display("[TB] FAIL start_ready_run got=%b exp=0", proc_ready); end
            total++; if (padr !== AW'(i + 1)) begin bad++; $display("[TB] FAIL start_padr_run got=%0d exp=%0d", padr, i + 1); end
        end
    endtask

    // Entered with padr=6, ir_pc=5
    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (padr !== 13'd6) begin bad++; $display("[TB] FAIL stall_padr got=%0d exp=6", padr); end
            total++; if (ir_pc !== 13'd5) begin bad++; $display("[TB] FAIL stall_ir_pc got=%0d exp=5", ir_pc); end
            total++; if (ir !== word_at(13'd5)) begin bad++; $display("[TB] FAIL stall_ir got=%h exp=%h", ir, word_at(13'd5)); end
            total++; if (ir_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid got=%b exp=1", ir_valid); end
        end
        stall = 1'b0;
        for (int i = 6; i <= 8; i++) begin
            step();
            total++; if (ir_pc !== AW'(i)) begin bad++; $display("[TB] FAIL unstall_ir_pc got=%0d exp=%0d", ir_pc, i); end
        end
        total++; if (padr !== 13'd9) begin bad++; $display("[TB] FAIL unstall_padr got=%0d exp=9", padr); end
    endtask

    // Entered with padr=9; redirect to idle together with stall
    task automatic test_redirect_idle();
        redir_en  = 1'b1;
        redir_adr = 13'd0;
        stall     = 1'b1;
        step();
        redir_en = 1'b0;
        stall    = 1'b0;
        total++; if (padr !== 13'd0) begin bad++; $display("[TB] FAIL redir_padr got=%0d exp=0", padr); end
        total++; if (ir_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_bubble got=%b exp=0", ir_valid); end
        total++; if (proc_ready !== 1'b1) begin bad++; $display("[TB] FAIL redir_ready got=%b exp=1", proc_ready); end
        step();
        total++; if (ir_valid !== 1'b1) begin bad++; $display("[TB] FAIL redir_refill got=%b exp=1", ir_valid); end
        total++; if (ir_pc !== 13'd0) begin bad++; $display("[TB] FAIL redir_ir_pc got=%0d exp=0", ir_pc); end
        total++; if (padr !== 13'd1) begin bad++; $display("[TB] FAIL redir_next_padr got=%0d exp=1", padr); end
    endtask

    task automatic test_wrap();
        proc_start = 1'b1;
        step();
        proc_start = 1'b0;
        redir_en   = 1'b1;
        redir_adr  = 13'h1FFF;
        step();
        redir_en = 1'b0;
        total++; if (padr !== 13'h1FFF) begin bad++; $display("[TB] FAIL wrap_padr got=%0d exp=8191", padr); end
        total++; if (proc_ready !== 1'b0) begin bad++; $display("[TB] FAIL wrap_ready_pre got=%b exp=0", proc_ready); end
        step();
        total++; if (padr !== 13'd0) begin bad++; $display("[TB] FAIL wrap_next_padr got=%0d exp=0", padr); end
        total++; if (ir_pc !== 13'h1FFF) begin bad++; $display("[TB] FAIL wrap_ir_pc got=%0d exp=8191", ir_pc); end
        total++; if (proc_ready !== 1'b0) begin bad++; $display("[TB] FAIL wrap_ready got=%b exp=0", proc_ready); end
        step();
        total++; if (ir_pc !== 13'd0) begin bad++; $display("[TB] FAIL wrap_ir_pc0 got=%0d exp=0", ir_pc); end
        total++; if (proc_ready !== 1'b0) begin bad++; $display("[TB] FAIL wrap_ready_after got=%b exp=0", proc_ready); end
    endtask

    // Reset asserted between edges must act without a clock edge
    task automatic test_async_reset();
        proc_start = 1'b1;
        step();
        proc_start = 1'b0;
        repeat (4) step();
        total++; if (padr !== 13'd5) begin bad++; $display("[TB] FAIL areset_setup got=%0d exp=5", padr); end
        #2 rst = 1'b1;
        #1;
        total++; if (padr !== 13'd0) begin bad++; $display("[TB] FAIL areset_padr got=%0d exp=0", padr); end
        total++; if (ir_valid !== 1'b0) begin bad++; $display("[TB] FAIL areset_valid got=%b exp=0", ir_valid); end
        total++; if (proc_ready !== 1'b1) begin bad++; $display("[TB] FAIL areset_ready got=%b exp=1", proc_ready); end
        total++; if (ir_pc !== 13'd0) begin bad++; $display("[TB] FAIL areset_ir_pc got=%0d exp=0", ir_pc); end
        rst = 1'b0;
    endtask

    // start beats a simultaneous redirect to idle; back-to-back redirects
    task automatic test_back_to_back();
        proc_start = 1'b1;
        redir_en   = 1'b1;
        redir_adr  = 13'd0;
        stall      = 1'b1;
        step();
        proc_start = 1'b0;
        stall      = 1'b0;
        total++; if (padr !== 13'd1) begin bad++; $display("[TB] FAIL prio_padr got=%0d exp=1", padr); end
        total++; if (proc_ready !== 1'b0) begin bad++; $display("[TB] FAIL prio_ready got=%b exp=0", proc_ready); end
        redir_adr = 13'd100;
        step();
        redir_adr = 13'd200;
        step();
        redir_en = 1'b0;
        total++; if (padr !== 13'd200) begin bad++; $display("[TB] FAIL b2b_padr got=%0d exp=200", padr); end
        total++; if (ir_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_valid got=%b exp=0", ir_valid); end
        step();
        total++; if (ir_pc !== 13'd200) begin bad++; $display("[TB] FAIL b2b_ir_pc got=%0d exp=200", ir_pc); end
        total++; if (ir_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_refill got=%b exp=1", ir_valid); end
    endtask

    task automatic test_jmp();
        proc_start = 1'b1;
        step();
        proc_start = 1'b0;
        redir_en   = 1'b1;
        redir_adr  = 13'd11;
        step();
        redir_en = 1'b0;
        jmp_en   = 1'b1;
        jmp_at   = 13'd11;
        total++; if (proc_ready !== 1'b0) begin bad++; $display("[TB] FAIL jmp_setup_ready got=%b exp=0", proc_ready); end
        step();
        total++; if (ir_pc !== 13'd11) begin bad++; $display("[TB] FAIL jmp_ir_pc got=%0d exp=11", ir_pc); end
        total++; if (ir_valid !== 1'b1) begin bad++; $display("[TB] FAIL jmp_valid got=%b exp=1", ir_valid); end
        total++; if (ir !== {5'b11010, 13'd0}) begin bad++; $display("[TB] FAIL jmp_ir got=%h exp=%h", ir, {5'b11010, 13'd0}); end
`ifdef FETCH_JMP_PREDECODE_EN
        total++; if (padr !== 13'd0) begin bad++; $display("[TB] FAIL jmp_padr got=%0d exp=0", padr); end
        total++; if (ir_taken !== 1'b1) begin bad++; $display("[TB] FAIL jmp_taken got=%b exp=1", ir_taken); end
        total++; if (proc_ready !== 1'b1) begin bad++; $display("[TB] FAIL jmp_ready got=%b exp=1", proc_ready); end
        step();
        total++; if (ir_pc !== 13'd0) begin bad++; $display("[TB] FAIL jmp_next_ir_pc got=%0d exp=0", ir_pc); end
        total++; if (ir_valid !== 1'b1) begin bad++; $display("[TB] FAIL jmp_no_bubble got=%b exp=1", ir_valid); end
        total++; if (ir_taken !== 1'b0) begin bad++; $display("[TB] FAIL jmp_taken_clr got=%b exp=0", ir_taken); end
`else
        total++; if (padr !== 13'd12) begin bad++; $display("[TB] FAIL jmp_padr got=%0d exp=12", padr); end
        total++; if (ir_taken !== 1'b0) begin bad++; $display("[TB] FAIL jmp_taken got=%b exp=0", ir_taken); end
        total++; if (proc_ready !== 1'b0) begin bad++; $display("[TB] FAIL jmp_ready got=%b exp=0", proc_ready); end
        redir_en  = 1'b1;
        redir_adr = 13'd0;
        step();
        redir_en = 1'b0;
        total++; if (padr !== 13'd0) begin bad++; $display("[TB] FAIL jmp_exec_padr got=%0d exp=0", padr); end
        total++; if (ir_valid !== 1'b0) begin bad++; $display("[TB] FAIL jmp_exec_bubble got=%b exp=0", ir_valid); end
        total++; if (proc_ready !== 1'b1) begin bad++; $display("[TB] FAIL jmp_exec_ready got=%b exp=1", proc_ready); end
`endif
        jmp_en = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        proc_start = 1'b0;
        stall      = 1'b0;
        redir_en   = 1'b0;
        redir_adr  = '0;
        jmp_en     = 1'b0;
        jmp_at     = '0;

        test_reset();
        test_start();
        test_stall();
        test_redirect_idle();
        test_wrap();
        test_async_reset();
        test_back_to_back();
        test_jmp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
